// File: rtl/ami_client_arbiter.sv
// ---------------------------------------------------------------------------
// ami_client_arbiter
//
// Shares one AMI memory interface between NUM_CLIENTS application clients.
// Reads and writes are arbitrated independently (round-robin or fixed
// priority) into two registered memory request ports. Read responses come
// back in request order; a tag FIFO remembers which client issued each
// outstanding read so the response can be steered back combinationally.
// Write-port responses are accepted and discarded.
//
// Handshake: a request/response word carries its own valid bit in the MSB.
// A transfer happens in any cycle where valid=1 and the matching grant=1;
// the producer holds the word stable while valid=1 and grant=0.
//
// Ports
//   clk               : clock, rising edge
//   reset             : asynchronous, active-low reset
//   client_req        : packed client requests, client i in slice i
//   client_req_grant  : per-client request accept (combinational)
//   client_resp       : packed client responses, client i in slice i
//   client_resp_grant : per-client response accept
//   mem_req0/_grant   : registered read request port
//   mem_req1/_grant   : registered write request port
//   mem_resp0/_grant  : in-order read responses
//   mem_resp1/_grant  : write-port responses (always accepted, dropped)
//   outstanding       : tag FIFO occupancy (reads in flight)
//   err_orphan        : sticky, a read response arrived with no tag
//
// AMI word layouts
//   request  : {valid, isWrite, addr[31:0], data[31:0], size[3:0]}
//   response : {valid, data[31:0], size[3:0]}
// ---------------------------------------------------------------------------
`ifndef AMI_REQUEST_BUS_WIDTH
`define AMI_REQUEST_BUS_WIDTH 70
`endif
`ifndef AMI_RESPONSE_BUS_WIDTH
`define AMI_RESPONSE_BUS_WIDTH 37
`endif

module ami_client_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int TAG_DEPTH   = 8,
    parameter int ARB_MODE    = 0
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_CLIENTS*`AMI_REQUEST_BUS_WIDTH-1:0]   client_req,
    output logic [NUM_CLIENTS-1:0]                          client_req_grant,
    output logic [NUM_CLIENTS*`AMI_RESPONSE_BUS_WIDTH-1:0]  client_resp,
    input  logic [NUM_CLIENTS-1:0]                          client_resp_grant,
    output logic [`AMI_REQUEST_BUS_WIDTH-1:0]               mem_req0,
    input  logic                                            mem_req0_grant,
    output logic [`AMI_REQUEST_BUS_WIDTH-1:0]               mem_req1,
    input  logic                                            mem_req1_grant,
    input  logic [`AMI_RESPONSE_BUS_WIDTH-1:0]              mem_resp0,
    output logic                                            mem_resp0_grant,
    input  logic [`AMI_RESPONSE_BUS_WIDTH-1:0]              mem_resp1,
    output logic                                            mem_resp1_grant,
    output logic [$clog2(TAG_DEPTH):0]                      outstanding,
    output logic                                            err_orphan
);
    localparam int RQW  = `AMI_REQUEST_BUS_WIDTH;
    localparam int RSW  = `AMI_RESPONSE_BUS_WIDTH;
    localparam int IDXW = $clog2(NUM_CLIENTS);
    localparam int PW   = $clog2(TAG_DEPTH);
    localparam int CW   = PW + 1;

    // Returns {found, index} of the first candidate at or after start,
    // scanning upward with wrap. Scanning offsets from high to low lets the
    // lowest offset overwrite the result last, so it wins.
    function automatic logic [IDXW:0] f_pick(input logic [NUM_CLIENTS-1:0] cand,
                                             input logic [IDXW-1:0]        start);
        logic [IDXW:0] result;
        int            idx;
        result = '0;
        for (int off = NUM_CLIENTS - 1; off >= 0; off--) begin
            idx = (int'(start) + off) % NUM_CLIENTS;
            if (cand[IDXW'(idx)]) result = {1'b1, IDXW'(idx)};
        end
        return result;
    endfunction

    function automatic logic [IDXW-1:0] f_next(input logic [IDXW-1:0] idx);
        return (idx == IDXW'(NUM_CLIENTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [RQW-1:0]         w_req_arr [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] w_rd_cand;
    logic [NUM_CLIENTS-1:0] w_wr_cand;

    logic [IDXW-1:0]        r_rd_ptr;
    logic [IDXW-1:0]        r_wr_ptr;
    logic [RQW-1:0]         r_mem_req0;
    logic [RQW-1:0]         r_mem_req1;
    logic [IDXW-1:0]        r_tag [TAG_DEPTH];
    logic [PW-1:0]          r_wr_tag;
    logic [PW-1:0]          r_rd_tag;
    logic [CW-1:0]          r_count;
    logic                   r_err;

    logic [IDXW:0]          w_rd_pick;
    logic [IDXW:0]          w_wr_pick;
    logic [IDXW-1:0]        w_rd_idx;
    logic [IDXW-1:0]        w_wr_idx;
    logic                   w_rd_load;
    logic                   w_wr_load;
    logic                   w_rd_gnt;
    logic                   w_wr_gnt;
    logic                   w_empty;
    logic [IDXW-1:0]        w_head;
    logic                   w_r0_valid;
    logic                   w_fwd;
    logic                   w_pop;
    logic                   w_unused_resp1;

    genvar g;
    generate
        for (g = 0; g < NUM_CLIENTS; g++) begin : g_client
            assign w_req_arr[g] = client_req[g*RQW +: RQW];
            assign w_rd_cand[g] = client_req[g*RQW + RQW - 1] & ~client_req[g*RQW + RQW - 2];
            assign w_wr_cand[g] = client_req[g*RQW + RQW - 1] &  client_req[g*RQW + RQW - 2];
            assign client_req_grant[g] = (w_rd_gnt && (w_rd_idx == IDXW'(g))) ||
                                         (w_wr_gnt && (w_wr_idx == IDXW'(g)));
            assign client_resp[g*RSW +: RSW] = (w_fwd && (w_head == IDXW'(g))) ? mem_resp0 : '0;
        end
    endgenerate

    // Fixed-priority mode simply always searches from client 0.
    assign w_rd_pick = f_pick(w_rd_cand, (ARB_MODE == 1) ? '0 : r_rd_ptr);
    assign w_wr_pick = f_pick(w_wr_cand, (ARB_MODE == 1) ? '0 : r_wr_ptr);
    assign w_rd_idx  = w_rd_pick[IDXW-1:0];
    assign w_wr_idx  = w_wr_pick[IDXW-1:0];

    // An output register accepts new contents when empty or being drained.
    assign w_rd_load = ~r_mem_req0[RQW-1] | mem_req0_grant;
    assign w_wr_load = ~r_mem_req1[RQW-1] | mem_req1_grant;

    // Occupancy is compared before any same-cycle pop: a slot freed by a
    // returning response is only reusable next cycle.
    assign w_rd_gnt = reset & w_rd_load & w_rd_pick[IDXW] & (r_count < CW'(TAG_DEPTH));
    assign w_wr_gnt = reset & w_wr_load & w_wr_pick[IDXW];

    assign w_empty    = (r_count == '0);
    assign w_head     = r_tag[r_rd_tag];
    assign w_r0_valid = mem_resp0[RSW-1];
    assign w_fwd      = reset & w_r0_valid & ~w_empty;
    assign w_pop      = w_r0_valid & ~w_empty & client_resp_grant[w_head];

    // With no tag to route to, the response is accepted and dropped.
    assign mem_resp0_grant = w_empty ? w_r0_valid : client_resp_grant[w_head];
    assign mem_resp1_grant = 1'b1;
    assign w_unused_resp1  = ^mem_resp1;

    assign mem_req0    = r_mem_req0;
    assign mem_req1    = r_mem_req1;
    assign outstanding = r_count;
    assign err_orphan  = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req0 <= '0;
            r_mem_req1 <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_rd_load) r_mem_req0 <= w_rd_gnt ? w_req_arr[w_rd_idx] : '0;
            if (w_wr_load) r_mem_req1 <= w_wr_gnt ? w_req_arr[w_wr_idx] : '0;
            if (w_rd_gnt && ARB_MODE == 0) r_rd_ptr <= f_next(w_rd_idx);
            if (w_wr_gnt && ARB_MODE == 0) r_wr_ptr <= f_next(w_wr_idx);
        end
    end

    // Tag storage needs no reset: entries are only read behind r_count.
    always_ff @(posedge clk) begin
        if (w_rd_gnt) r_tag[r_wr_tag] <= w_rd_idx;
    end

    // Pointers are PW bits wide over a power-of-two depth, so they wrap
    // modulo TAG_DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_tag <= '0;
            r_rd_tag <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_rd_gnt) r_wr_tag <= r_wr_tag + 1'b1;
            if (w_pop)    r_rd_tag <= r_rd_tag + 1'b1;
            if (w_rd_gnt && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_rd_gnt && w_pop) r_count <= r_count - 1'b1;
            if (w_r0_valid && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ami_client_arbiter.sv
`timescale 1ns/1ps
`ifndef AMI_REQUEST_BUS_WIDTH
`define AMI_REQUEST_BUS_WIDTH 70
`endif
`ifndef AMI_RESPONSE_BUS_WIDTH
`define AMI_RESPONSE_BUS_WIDTH 37
`endif

module tb_ami_client_arbiter;
    localparam int N   = 4;
    localparam int TAG = 8;
    localparam int RQW = `AMI_REQUEST_BUS_WIDTH;
    localparam int RSW = `AMI_RESPONSE_BUS_WIDTH;
    localparam int PRW = N * RSW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [RQW-1:0]   req_arr [N];
    logic [N*RQW-1:0] client_req;
    logic [N-1:0]     client_req_grant;
    logic [PRW-1:0]   client_resp;
    logic [N-1:0]     client_resp_grant;
    logic [RQW-1:0]   mem_req0, mem_req1;
    logic             mem_req0_grant, mem_req1_grant;
    logic [RSW-1:0]   mem_resp0, mem_resp1;
    logic             mem_resp0_grant, mem_resp1_grant;
    logic [3:0]       outstanding;
    logic             err_orphan;

    // fixed-priority instance, shares all inputs
    logic [N-1:0]     p_grant;
    logic [RQW-1:0]   p_mem_req0;
    logic [PRW-1:0]   p_unused_resp;
    logic [RQW-1:0]   p_unused_req1;
    logic             p_unused_r0g, p_unused_r1g, p_unused_err;
    logic [3:0]       p_unused_out;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_pack
            assign client_req[g*RQW +: RQW] = req_arr[g];
        end
    endgenerate

    ami_client_arbiter #(.NUM_CLIENTS(N), .TAG_DEPTH(TAG), .ARB_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .client_req(client_req), .client_req_grant(client_req_grant),
        .client_resp(client_resp), .client_resp_grant(client_resp_grant),
        .mem_req0(mem_req0), .mem_req0_grant(mem_req0_grant),
        .mem_req1(mem_req1), .mem_req1_grant(mem_req1_grant),
        .mem_resp0(mem_resp0), .mem_resp0_grant(mem_resp0_grant),
        .mem_resp1(mem_resp1), .mem_resp1_grant(mem_resp1_grant),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    ami_client_arbiter #(.NUM_CLIENTS(N), .TAG_DEPTH(TAG), .ARB_MODE(1)) dut_prio (
        .clk(clk), .reset(reset),
        .client_req(client_req), .client_req_grant(p_grant),
        .client_resp(p_unused_resp), .client_resp_grant(client_resp_grant),
        .mem_req0(p_mem_req0), .mem_req0_grant(mem_req0_grant),
        .mem_req1(p_unused_req1), .mem_req1_grant(mem_req1_grant),
        .mem_resp0(mem_resp0), .mem_resp0_grant(p_unused_r0g),
        .mem_resp1(mem_resp1), .mem_resp1_grant(p_unused_r1g),
        .outstanding(p_unused_out), .err_orphan(p_unused_err)
    );

    // ---------------- scoreboard / reference model ----------------
    int             n_checks = 0;
    int             n_errors = 0;
    int             m_fifo[$];      // client index of each read in flight, oldest first
    int             m_rd_ptr, m_wr_ptr;
    logic [RQW-1:0] m_req0, m_req1;
    bit             m_err;

    logic [N-1:0]   obs_grant, obs_p_grant;
    logic           obs_r0g;
    logic [PRW-1:0] obs_resp;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RQW-1:0] mk_req(input bit v, input bit w, input logic [31:0] addr, input logic [31:0] data);
        return {v, w, addr, data, 4'h8};
    endfunction

    function automatic logic [RSW-1:0] mk_resp(input bit v, input logic [31:0] data);
        return {v, data, 4'h8};
    endfunction

    function automatic logic [31:0] addr_of(input logic [RQW-1:0] r);
        return r[67:36];
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        m_req0   = '0;
        m_req1   = '0;
        m_err    = 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        for (int i = 0; i < N; i++) req_arr[i] = '0;
        client_resp_grant = '1;
        mem_req0_grant    = 1'b1;
        mem_req1_grant    = 1'b1;
        mem_resp0         = '0;
        mem_resp1         = '0;
    endtask

    // Called just after a falling edge with inputs applied: checks every
    // output against the model, then advances the model over the rising edge.
    task automatic step();
        int   rd_k, wr_k, c, head;
        bit   nonempty, rv, rd_ok, wr_ok;
        logic [N-1:0]   exp_grant;
        logic [PRW-1:0] exp_resp;
        #1;
        rd_ok = (!m_req0[RQW-1] || mem_req0_grant) && (m_fifo.size() < TAG);
        wr_ok = (!m_req1[RQW-1] || mem_req1_grant);
        rd_k = -1;
        wr_k = -1;
        for (int o = 0; o < N; o++) begin
            c = (m_rd_ptr + o) % N;
            if (rd_k < 0 && req_arr[c][RQW-1] && !req_arr[c][RQW-2]) rd_k = c;
            c = (m_wr_ptr + o) % N;
            if (wr_k < 0 && req_arr[c][RQW-1] && req_arr[c][RQW-2]) wr_k = c;
        end
        if (!rd_ok) rd_k = -1;
        if (!wr_ok) wr_k = -1;
        exp_grant = '0;
        if (rd_k >= 0) exp_grant = exp_grant | (N'(1) << rd_k);
        if (wr_k >= 0) exp_grant = exp_grant | (N'(1) << wr_k);
        nonempty = (m_fifo.size() > 0);
        head     = nonempty ? m_fifo[0] : 0;
        rv       = mem_resp0[RSW-1];
        exp_resp = '0;
        if (rv && nonempty) exp_resp = PRW'(mem_resp0) << (head * RSW);

        check("req_grant",   256'(client_req_grant), 256'(exp_grant));
        check("mem_req0",    256'(mem_req0),         256'(m_req0));
        check("mem_req1",    256'(mem_req1),         256'(m_req1));
        check("outstanding", 256'(outstanding),      256'(m_fifo.size()));
        check("resp0_grant", 256'(mem_resp0_grant),  256'(nonempty ? client_resp_grant[head] : rv));
        check("resp1_grant", 256'(mem_resp1_grant),  256'(1));
        check("client_resp", 256'(client_resp),      256'(exp_resp));
        check("err_orphan",  256'(err_orphan),       256'(m_err));
        obs_grant   = client_req_grant;
        obs_p_grant = p_grant;
        obs_r0g     = mem_resp0_grant;
        obs_resp    = client_resp;

        @(posedge clk);
        if (rv && nonempty && client_resp_grant[head]) void'(m_fifo.pop_front());
        if (rd_k >= 0) m_fifo.push_back(rd_k);
        if (rv && !nonempty) m_err = 1'b1;
        if (!m_req0[RQW-1] || mem_req0_grant) m_req0 = (rd_k >= 0) ? req_arr[rd_k] : '0;
        if (!m_req1[RQW-1] || mem_req1_grant) m_req1 = (wr_k >= 0) ? req_arr[wr_k] : '0;
        if (rd_k >= 0) m_rd_ptr = (rd_k + 1) % N;
        if (wr_k >= 0) m_wr_ptr = (wr_k + 1) % N;
        @(negedge clk);
    endtask

    task automatic do_reset();
        logic [N-1:0] vbits;
        for (int i = 0; i < N; i++) req_arr[i] = mk_req(1'b1, i[0], $urandom, $urandom);
        mem_resp0 = mk_resp(1'b1, $urandom);
        reset = 1'b0;
        #1;
        vbits = '0;
        for (int i = 0; i < N; i++) vbits[i] = client_resp[i*RSW + RSW - 1];
        check("rst_grant",       256'(client_req_grant), 256'(0));
        check("rst_resp_valid",  256'(vbits),            256'(0));
        check("rst_outstanding", 256'(outstanding),      256'(0));
        check("rst_req0_valid",  256'(mem_req0[RQW-1]),  256'(0));
        check("rst_req1_valid",  256'(mem_req1[RQW-1]),  256'(0));
        check("rst_err",         256'(err_orphan),       256'(0));
        model_reset();
        @(negedge clk);
        set_idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_phase(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            for (int i = 0; i < N; i++)
                req_arr[i] = mk_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
            mem_req0_grant    = $urandom_range(0, 3) != 0;
            mem_req1_grant    = $urandom_range(0, 3) != 0;
            client_resp_grant = N'($urandom);
            if (m_fifo.size() > 0) mem_resp0 = mk_resp($urandom_range(0, 2) != 0, $urandom);
            else                   mem_resp0 = mk_resp($urandom_range(0, 19) == 0, $urandom);
            mem_resp1 = mk_resp($urandom_range(0, 1) == 1, $urandom);
            step();
        end
        set_idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cnt;
        logic [RSW-1:0] r_a, r_b;
        set_idle();
        @(negedge clk);
        do_reset();

        // orphan response straight after reset; flag stays set
        mem_resp0 = mk_resp(1'b1, 32'hdead_0001);
        step();
        check("orphan_grant", 256'(obs_r0g), 256'(1));
        mem_resp0 = '0;
        for (int k = 0; k < 3; k++) step();
        check("orphan_sticky", 256'(err_orphan), 256'(1));

        // random traffic, then reset with reads still in flight
        do_reset();
        rand_phase(300);
        for (int i = 0; i < N; i++) req_arr[i] = mk_req(1'b1, 1'b0, 32'h100 + i, 32'h0);
        mem_req0_grant = 1'b1;
        step();
        step();
        check("inflight_before_reset", 256'(outstanding != 0), 256'(1));
        do_reset();
        mem_resp0 = mk_resp(1'b1, 32'hdead_0002);
        step();
        mem_resp0 = '0;
        step();
        check("orphan_after_midreset", 256'(err_orphan), 256'(1));

        // round-robin rotation with all four reading
        do_reset();
        for (int i = 0; i < N; i++) req_arr[i] = mk_req(1'b1, 1'b0, 32'h1000 + i, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_grant", 256'(obs_grant), 256'(N'(1) << (k % N)));
            check("rr_mem_req0", 256'(addr_of(mem_req0)), 256'(32'h1000 + (k % N)));
        end

        // fixed priority: client 1 always wins over client 3
        do_reset();
        req_arr[1] = mk_req(1'b1, 1'b0, 32'h2001, 32'h0);
        req_arr[3] = mk_req(1'b1, 1'b0, 32'h2003, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("prio_grant", 256'(obs_p_grant), 256'(4'b0010));
            check("prio_mem_req0", 256'(addr_of(p_mem_req0)), 256'(32'h2001));
        end

        // tag FIFO fills at TAG, then one grant per returned response
        do_reset();
        req_arr[0] = mk_req(1'b1, 1'b0, 32'h3000, 32'h0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_grant[0]) cnt++;
        end
        check("full_grants", 256'(cnt), 256'(TAG));
        check("full_outstanding", 256'(outstanding), 256'(TAG));
        for (int k = 0; k < 3; k++) begin
            mem_resp0 = mk_resp(1'b1, 32'h3300 + k);
            step();
            check("full_pop_no_grant", 256'(obs_grant), 256'(0));
            mem_resp0 = '0;
            step();
            check("full_refill_grant", 256'(obs_grant), 256'(4'b0001));
        end
        check("full_outstanding_end", 256'(outstanding), 256'(TAG));

        // simultaneous read (client 2) and write (client 0)
        do_reset();
        req_arr[2] = mk_req(1'b1, 1'b0, 32'h4002, 32'h0);
        req_arr[0] = mk_req(1'b1, 1'b1, 32'h4000, 32'h5555);
        step();
        check("rw_grant", 256'(obs_grant), 256'(4'b0101));
        check("rw_mem_req0", 256'(addr_of(mem_req0)), 256'(32'h4002));
        check("rw_mem_req1", 256'(addr_of(mem_req1)), 256'(32'h4000));

        // in-order responses with client 3 back-pressuring
        do_reset();
        req_arr[3] = mk_req(1'b1, 1'b0, 32'h5003, 32'h0);
        step();
        req_arr[3] = '0;
        req_arr[1] = mk_req(1'b1, 1'b0, 32'h5001, 32'h0);
        step();
        req_arr[1] = '0;
        r_a = mk_resp(1'b1, 32'haaaa_0001);
        r_b = mk_resp(1'b1, 32'hbbbb_0002);
        mem_resp0 = r_a;
        client_resp_grant = 4'b0111;
        for (int k = 0; k < 2; k++) begin
            step();
            check("hold_resp3", 256'(obs_resp[3*RSW +: RSW]), 256'(r_a));
            check("hold_r0g", 256'(obs_r0g), 256'(0));
        end
        client_resp_grant = '1;
        step();
        check("ra_resp3", 256'(obs_resp[3*RSW +: RSW]), 256'(r_a));
        check("ra_r0g", 256'(obs_r0g), 256'(1));
        mem_resp0 = r_b;
        step();
        check("rb_resp1", 256'(obs_resp[1*RSW +: RSW]), 256'(r_b));
        check("rb_resp3_valid", 256'(obs_resp[3*RSW + RSW - 1]), 256'(0));
        mem_resp0 = '0;
        step();
        check("order_outstanding", 256'(outstanding), 256'(0));
        check("order_no_orphan", 256'(err_orphan), 256'(0));

        // more random traffic from a clean start
        do_reset();
        rand_phase(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
